pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_btb.sv | 87 ++++++++
 rtl/pc_fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch unit and its branch target buffer.
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // 2-bit saturating branch-direction counter
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Move the counter one step towards the resolved direction, saturating at the ends
  function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : ctr_e'(c + 2'd1);
    end
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: asynchronous lookup, synchronous update.
// Addresses arrive as word addresses (byte address bits [1:0] already dropped).
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned Depth = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-3:0] lookup_addr_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-3:0] upd_addr_i,
  input  logic [XLEN-3:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int unsigned IW   = $clog2(Depth);
  localparam int unsigned TagW = XLEN - 2 - IW;

  logic [Depth-1:0] valid_q;
  logic [TagW-1:0]  tag_q [Depth];
  logic [XLEN-3:0]  tgt_q [Depth];
  ctr_e             ctr_q [Depth];

  logic [IW-1:0]   lk_idx, upd_idx;
  logic [TagW-1:0] lk_tag, upd_tag;
  logic            lk_hit, upd_hit;
  logic            alloc, ctr_we, tgt_we;
  ctr_e            ctr_d;

  assign lk_idx  = lookup_addr_i[IW-1:0];
  assign lk_tag  = lookup_addr_i[XLEN-3:IW];
  assign upd_idx = upd_addr_i[IW-1:0];
  assign upd_tag = upd_addr_i[XLEN-3:IW];

  // Lookup sees pre-update contents; writes land on the clock edge
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && (ctr_q[lk_idx] >= WT);
    pred_target_o = pred_taken_o ? {tgt_q[lk_idx], 2'b00} : '0;
  end

  // Decode the resolution strobe into entry write enables and the new counter value
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    alloc   = 1'b0;
    ctr_we  = 1'b0;
    tgt_we  = 1'b0;
    ctr_d   = SNT;
    if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_we = 1'b1;
        ctr_d  = ctr_update(ctr_q[upd_idx], upd_taken_i);
        tgt_we = upd_taken_i;
      end else if (upd_taken_i) begin
        // Allocation evicts whatever occupied this index
        alloc  = 1'b1;
        ctr_we = 1'b1;
        ctr_d  = WT;
        tgt_we = 1'b1;
      end
    end
  end

  // Valid bits and counters: cleared by reset, reset blocks any write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        ctr_q[i] <= SNT;
      end
    end else begin
      if (alloc)  valid_q[upd_idx] <= 1'b1;
      if (ctr_we) ctr_q[upd_idx]   <= ctr_d;
    end
  end

  // Tags and targets carry no reset; they are qualified by the valid bit
  always_ff @(posedge clk_i) begin
    if (!rst_i && alloc)  tag_q[upd_idx] <= upd_tag;
    if (!rst_i && tgt_we) tgt_q[upd_idx] <= upd_target_i;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC generator with optional BTB-based next-PC prediction.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16,
  parameter bit              BTB_EN    = 1'b1
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            suspend,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] PC4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;

  // Byte-offset bits of redirect and update addresses are ignored
  logic unused_low;
  assign unused_low = ^{flush_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  if (BTB_EN) begin : gen_btb
    pc_btb #(
      .XLEN  (XLEN),
      .Depth (BTB_DEPTH)
    ) u_btb (
      .clk_i         (cpu_clk),
      .rst_i         (cpu_rst),
      .lookup_addr_i (pc_q[XLEN-1:2]),
      .pred_taken_o  (pred_taken),
      .pred_target_o (pred_target),
      .upd_valid_i   (upd_valid),
      .upd_addr_i    (upd_pc[XLEN-1:2]),
      .upd_target_i  (upd_target[XLEN-1:2]),
      .upd_taken_i   (upd_taken)
    );
  end else begin : gen_no_btb
    logic unused_upd;
    assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
  end

  // Next-PC select: flush > suspend > prediction > sequential
  always_comb begin
    PC4 = pc_q + XLEN'(4);
    if (flush) begin
      pc_d = {flush_pc[XLEN-1:2], 2'b00};
    end else if (suspend) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end else begin
      pc_d = PC4;
    end
  end

  // PC and valid registers
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  assign pc    = pc_q;
  assign valid = valid_q;

endmodule
